// File: rtl/mmio_led_pkg.sv
// Shared definitions for the memory-mapped LED / interval-timer peripheral.
package mmio_led_pkg;

    localparam logic [7:0] LED_OFS    = 8'h00;
    localparam logic [7:0] CTRL_OFS   = 8'h04;
    localparam logic [7:0] PERIOD_OFS = 8'h08;
    localparam logic [7:0] COUNT_OFS  = 8'h0C;
    localparam logic [7:0] STATUS_OFS = 8'h10;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_AUTO_BIT = 1;
    localparam int CTRL_DIR_BIT  = 2;

    localparam int STATUS_EXP_BIT = 0;

    typedef struct packed {
        logic dir;
        logic auto;
        logic en;
    } ctrl_t;

    // Rotate an LED pattern by one position: dir=0 left, dir=1 right.
    function automatic logic [7:0] rotate8(input logic [7:0] v, input logic dir);
        return dir ? {v[0], v[7:1]} : {v[6:0], v[7]};
    endfunction

endpackage

// File: rtl/mmio_led_timer_tick_gen.sv
// Prescaler: emits a one-cycle step every CLK_DIV clocks while running.
module tick_gen #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic restart,
    output logic step
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;

    // A restart on the same edge as a wrap suppresses the step.
    assign step = run & ~restart & (presc_q == LAST);

    // Next prescaler value: held at zero when idle or restarting, wraps on step.
    always_comb begin
        presc_d = presc_q;
        if (restart || !run || step)
            presc_d = '0;
        else
            presc_d = presc_q + 1'b1;
    end

    // Prescaler register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset)
            presc_q <= '0;
        else
            presc_q <= presc_d;
    end

endmodule

// File: rtl/mmio_led_timer.sv
// LED register plus prescaled interval timer with optional auto-rotate,
// decoded from a 256-byte window on the core's data-memory bus.
module mmio_led_timer
    import mmio_led_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
    parameter int          CLK_DIV   = 16,
    parameter int          CNT_W     = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic        Sel,
    output logic [31:0] ReadData,
    output logic [7:0]  led,
    output logic        tick
);

    logic [7:0]       led_q, led_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             exp_q, exp_d;
    logic             tick_q, tick_d;

    logic [7:0] ofs;
    logic       we;
    logic       wr_led, wr_ctrl, wr_period, wr_status;
    ctrl_t      ctrl_wr;
    logic       restart, run, step, expire;
    logic       unused_wdata;

    assign ofs = DataAdr[7:0];
    assign Sel = (DataAdr[31:8] == BASE_ADDR[31:8]);
    assign we  = MemWrite & Sel;

    assign wr_led    = we && (ofs == LED_OFS);
    assign wr_ctrl   = we && (ofs == CTRL_OFS);
    assign wr_period = we && (ofs == PERIOD_OFS);
    assign wr_status = we && (ofs == STATUS_OFS);

    assign ctrl_wr = ctrl_t'(WriteData[2:0]);

    // Only a PERIOD write or an EN rising edge restarts the interval.
    assign restart = wr_period | (wr_ctrl & ctrl_wr.en & ~ctrl_q.en);
    assign run     = ctrl_q.en & (period_q != '0);
    assign expire  = step & (count_q == period_q - CNT_W'(1));

    assign unused_wdata = ^WriteData;

    tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .restart (restart),
        .step    (step)
    );

    // Register-file next state, with CPU-write vs timer-event priorities.
    always_comb begin
        led_d    = led_q;
        ctrl_d   = ctrl_q;
        period_d = period_q;
        count_d  = count_q;
        exp_d    = exp_q;
        tick_d   = expire;

        if (wr_led)
            led_d = WriteData[7:0];
        else if (expire && ctrl_q.auto)
            led_d = rotate8(led_q, ctrl_q.dir);

        if (wr_ctrl)
            ctrl_d = ctrl_wr;

        if (wr_period)
            period_d = WriteData[CNT_W-1:0];

        if (restart)
            count_d = '0;
        else if (step)
            count_d = expire ? '0 : count_q + CNT_W'(1);

        if (expire)
            exp_d = 1'b1;
        else if (wr_status && WriteData[STATUS_EXP_BIT])
            exp_d = 1'b0;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            led_q    <= '0;
            ctrl_q   <= '0;
            period_q <= '0;
            count_q  <= '0;
            exp_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            led_q    <= led_d;
            ctrl_q   <= ctrl_d;
            period_q <= period_d;
            count_q  <= count_d;
            exp_q    <= exp_d;
            tick_q   <= tick_d;
        end
    end

    // Zero-latency load data; zero outside the window and at unmapped offsets.
    always_comb begin
        ReadData = '0;
        if (Sel) begin
            case (ofs)
                LED_OFS:    ReadData[7:0]       = led_q;
                CTRL_OFS:   ReadData[2:0]       = ctrl_q;
                PERIOD_OFS: ReadData[CNT_W-1:0] = period_q;
                COUNT_OFS:  ReadData[CNT_W-1:0] = count_q;
                STATUS_OFS: ReadData[0]         = exp_q;
                default:    ReadData            = '0;
            endcase
        end
    end

    assign led  = led_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_mmio_led_timer.sv
// Directed bench for mmio_led_timer with hand-computed expectations.
module tb_mmio_led_timer;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        Sel;
    logic [31:0] ReadData;
    logic [7:0]  led;
    logic        tick;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int tick_total = 0;

    mmio_led_timer #(
        .BASE_ADDR (32'hFFFF_FF00),
        .CLK_DIV   (16),
        .CNT_W     (24)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .Sel       (Sel),
        .ReadData  (ReadData),
        .led       (led),
        .tick      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (tick === 1'b1) tick_total <= tick_total + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue a store whose write edge is the posedge after the next negedge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        @(negedge clk);
        MemWrite  = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        DataAdr = a;
        #1;
        d = ReadData;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_tick(input int limit, output int c);
        c = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (tick === 1'b1) begin
                c = cyc;
                return;
            end
        end
    endtask

    logic [31:0] rd;
    int e, c, t0;

    initial begin
        reset     = 1'b0;
        MemWrite  = 1'b0;
        DataAdr   = 32'h0;
        WriteData = 32'h0;

        // Reset and idle behaviour
        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk("rst_led", {24'h0, led}, 32'h00);
        chk("rst_tick", {31'h0, tick}, 32'h0);
        bus_read(BASE + 32'h08, rd); chk("rst_period", rd, 32'h0);
        bus_read(BASE + 32'h0C, rd); chk("rst_count", rd, 32'h0);
        bus_read(BASE + 32'h10, rd); chk("rst_status", rd, 32'h0);
        t0 = tick_total;
        repeat (1000) @(negedge clk);
        chk("rst_no_tick", tick_total, t0);

        // LED register, decode and unmapped offsets
        bus_write(BASE + 32'h00, 32'h0000_00A5);
        chk("led_a5", {24'h0, led}, 32'hA5);
        bus_read(BASE + 32'h00, rd); chk("rd_led", rd, 32'h0000_00A5);
        bus_write(BASE + 32'h40, 32'hFFFF_FFFF);
        bus_read(BASE + 32'h40, rd); chk("rd_unmapped", rd, 32'h0);
        bus_read(BASE + 32'h00, rd); chk("led_kept", rd, 32'h0000_00A5);
        chk("sel_in", {31'h0, Sel}, 32'h1);
        bus_read(32'd100, rd);
        chk("sel_out", {31'h0, Sel}, 32'h0);
        chk("rd_out", rd, 32'h0);
        bus_write(BASE + 32'h08, 32'hFFFF_FFFF);
        bus_read(BASE + 32'h08, rd); chk("period_width", rd, 32'h00FF_FFFF);

        // Interval timer: PERIOD=3 -> tick every 48 clocks
        bus_write(BASE + 32'h08, 32'd3);
        bus_write(BASE + 32'h04, 32'h1);
        e = cyc;
        bus_read(BASE + 32'h04, rd); chk("rd_ctrl", rd, 32'h1);
        wait_tick(200, c); chk("tick1_lat", c - e, 48);
        @(negedge clk);     chk("tick_width", {31'h0, tick}, 32'h0);
        wait_tick(200, c); chk("tick2_lat", c - e, 96);
        bus_read(BASE + 32'h10, rd); chk("exp_set", rd, 32'h1);
        bus_write(BASE + 32'h10, 32'h1);
        bus_read(BASE + 32'h10, rd); chk("exp_clr", rd, 32'h0);
        bus_write(BASE + 32'h04, 32'h0);

        // Auto-rotate left, then right from current value
        bus_write(BASE + 32'h00, 32'h81);
        bus_write(BASE + 32'h08, 32'd2);
        bus_write(BASE + 32'h04, 32'h3);
        wait_tick(200, c); chk("rotl_1", {24'h0, led}, 32'h03);
        wait_tick(200, c); chk("rotl_2", {24'h0, led}, 32'h06);
        wait_tick(200, c); chk("rotl_3", {24'h0, led}, 32'h0C);
        bus_write(BASE + 32'h04, 32'h7);
        wait_tick(200, c); chk("rotr_1", {24'h0, led}, 32'h06);
        wait_tick(200, c); chk("rotr_2", {24'h0, led}, 32'h03);
        bus_write(BASE + 32'h04, 32'h0);

        // Collisions
        bus_write(BASE + 32'h00, 32'h10);
        bus_write(BASE + 32'h08, 32'd2);
        bus_write(BASE + 32'h04, 32'h3);
        e = cyc;
        wait_until(e + 30);
        bus_write(BASE + 32'h00, 32'h55);
        chk("col_led_tick", {31'h0, tick}, 32'h1);
        chk("col_led_val", {24'h0, led}, 32'h55);
        wait_until(e + 62);
        bus_write(BASE + 32'h10, 32'h1);
        chk("col_w1c_tick", {31'h0, tick}, 32'h1);
        chk("col_w1c_led", {24'h0, led}, 32'hAA);
        bus_read(BASE + 32'h10, rd); chk("col_w1c_exp", rd, 32'h1);
        wait_until(e + 94);
        bus_write(BASE + 32'h08, 32'd2);
        chk("col_per_tick", {31'h0, tick}, 32'h0);
        chk("col_per_led", {24'h0, led}, 32'hAA);
        bus_read(BASE + 32'h0C, rd); chk("col_per_count", rd, 32'h0);
        wait_tick(200, c); chk("col_per_restart", c - e, 128);

        // Reset mid-run with AUTO on
        bus_write(BASE + 32'h00, 32'h3C);
        bus_write(BASE + 32'h08, 32'd3);
        e = cyc;
        wait_until(e + 40);
        bus_read(BASE + 32'h0C, rd); chk("mid_count", rd, 32'h2);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk("mid_led", {24'h0, led}, 32'h0);
        chk("mid_tick", {31'h0, tick}, 32'h0);
        bus_read(BASE + 32'h00, rd); chk("mid_rd_led", rd, 32'h0);
        bus_read(BASE + 32'h04, rd); chk("mid_ctrl", rd, 32'h0);
        bus_read(BASE + 32'h08, rd); chk("mid_period", rd, 32'h0);
        bus_read(BASE + 32'h0C, rd); chk("mid_count_rst", rd, 32'h0);
        bus_read(BASE + 32'h10, rd); chk("mid_status", rd, 32'h0);
        t0 = tick_total;
        repeat (1000) @(negedge clk);
        chk("mid_no_tick", tick_total, t0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mmio_led_timer.md
# mmio_led_timer

Memory-mapped LED and interval-timer peripheral on the data-memory bus of the RV32I core, alongside data memory, in both the single-cycle and pipelined builds. It consumes the core's store and load traffic (`DataAdr`, `WriteData`, `MemWrite`) in a 256-byte window and drives the board `led[7:0]` output. It also provides a prescaled interval timer so rotating-LED programs get deterministic delays. An optional hardware auto-rotate mode shifts the LED pattern on every timer expiry.

## Interface
- `BASE_ADDR`, 32'hFFFF_FF00 — window base; bits [7:0] must be zero.
- `CLK_DIV`, 16 — prescaler ratio, ≥ 1; the timer advances once every `CLK_DIV` clocks.
- `CNT_W`, 24 — width of the PERIOD and COUNT registers.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — synchronous, active-low reset; sampled on `clk` rising edge; 0 = reset.
- `MemWrite`  in  1  — store strobe from the core.
- `DataAdr`  in  32  — byte address; word-aligned accesses only.
- `WriteData`  in  32  — store data.
- `Sel`  out  1  — combinational; 1 when `DataAdr[31:8] == BASE_ADDR[31:8]`. Top uses it to select `ReadData` and suppress the dmem write.
- `ReadData`  out  32  — combinational load data; 0 when `Sel` = 0.
- `led`  out  8  — registered LED drive.
- `tick`  out  1  — one-cycle pulse on each timer expiry.

## Operation
- Register map (offset = `DataAdr[7:0]`):
  - 0x00 LED: RW; bits [7:0] drive `led`.
  - 0x04 CTRL: RW.
    - bit0 EN: timer run.
    - bit1 AUTO: rotate LED on expiry.
    - bit2 DIR: 0 = rotate left, 1 = rotate right.
  - 0x08 PERIOD: RW, `CNT_W` bits.
  - 0x0C COUNT: RO.
  - 0x10 STATUS: bit0 EXP, sticky; write 1 to clear.
  - All other offsets: reads return 0, writes are ignored.
- Unused upper bits read as 0.
- A write occurs when `MemWrite & Sel` is 1 on a rising edge.
- Prescaler:
  - Counts 0 to `CLK_DIV`−1 while EN=1 and PERIOD≠0.
  - Emits an internal `step` pulse on wrap.
  - Held at 0 otherwise.
- On `step`:
  - If COUNT == PERIOD−1: COUNT←0, EXP←1, `tick`=1 for that cycle, and the LED rotates by 1 in direction DIR if AUTO=1.
  - Otherwise: COUNT←COUNT+1.
- PERIOD=0: timer inert; COUNT stays 0 and no expiry ever occurs.
- A write to PERIOD, or to CTRL with EN changing 0→1, clears COUNT and the prescaler on the same edge.
- Clearing EN freezes COUNT and clears the prescaler.
- Simultaneous events:
  - CPU write to LED on the same edge as an auto-rotate: the CPU value wins.
  - W1C of EXP on the same edge as an expiry: EXP stays 1 (set wins).
  - Write to PERIOD on the same edge as an expiry: the restart wins, so no `tick` and no rotate occur.

## Timing
- Reset values (reset=0 at an edge): `led`=0x00, CTRL=0, PERIOD=0, COUNT=0, prescaler=0, EXP=0, `tick`=0.
- `ReadData` and `Sel` are combinational functions of `DataAdr` and current register state. Zero-cycle load latency, as the single-cycle core requires.
- Written values are visible on `led` and in readback starting the cycle after the write edge.
- Expiry period from restart = PERIOD × `CLK_DIV` clocks. The first `tick` appears PERIOD×`CLK_DIV` edges after the restart edge.
- `tick` is registered, asserted one cycle, coincident with the EXP set and the LED rotate.
- Reset asserted mid-count returns everything to reset values on that edge; there is no partial state.

## Structure
- Package `mmio_led_pkg`:
  - Register offset localparams: `LED_OFS`, `CTRL_OFS`, `PERIOD_OFS`, `COUNT_OFS`, `STATUS_OFS`.
  - CTRL bit indices.
  - A packed `ctrl_t` struct {dir, auto, en}.
- Sub-module `tick_gen`:
  - Prescaler with parameter `CLK_DIV`.
  - Inputs: run, restart.
  - Output: one-cycle `step`.
- The top level of the block holds the register file, address decode, COUNT/EXP logic and the rotator.

## Test plan
- Reset: hold reset=0 for 2 cycles, release → `led`=0x00, ReadData at 0x08/0x0C/0x10 = 0, `tick` never pulses over 1000 cycles.
- Store 0xA5 to BASE+0x00 → `led`=0xA5 next cycle; load BASE+0x00 returns 0x0000_00A5; store to BASE+0x40 has no effect and reads 0; `Sel`=0 at address 100.
- Timer: `CLK_DIV`=16, PERIOD=3, CTRL=0x1 → `tick` every 48 clocks, first one 48 clocks after the CTRL write; EXP reads 1; writing 1 to STATUS clears it.
- Auto-rotate: LED=0x81, PERIOD=2, CTRL=0x3 → `led` sequence 0x03, 0x06, 0x0C; then with CTRL=0x7 it rotates right from the current value.
- Collisions:
  - LED store on the same edge as a rotate → stored value is kept.
  - STATUS W1C on the same edge as an expiry → EXP=1.
  - PERIOD write on the expiry edge → no `tick`, COUNT=0.
- Reset mid-run: assert reset=0 when COUNT=2 with AUTO on → all registers return to reset values, and no `tick` occurs for 1000 cycles after release.
